// File: rtl/pkt_bus_pkg.sv
// Shared definitions for the 134b-style parser pipeline bus and the replay source.
// Flit layout (FLIT_W = DATA_W+6): {hdr[1:0], vbytes[3:0], data[DATA_W-1:0]}.
// Replay RAM entry layout: {last, vld, flit[FLIT_W-1:0]}.
package pkt_bus_pkg;

    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned FLIT_W_DEF = DATA_W_DEF + 6;

    // Header codes carried in the top two flit bits
    localparam logic [1:0] HDR_FIRST = 2'b01;
    localparam logic [1:0] HDR_BODY  = 2'b11;

    // Entry control bits, as offsets above the flit field
    localparam int unsigned ENTRY_VLD_OFS  = 0;
    localparam int unsigned ENTRY_LAST_OFS = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pkt_flit_ram.sv
// Simple dual-port flit RAM: one write port, one synchronous read port.
// A read and write to the same address in one cycle returns the old contents.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr           read request; rd_data valid the following cycle
module pkt_flit_ram #(
    parameter  int unsigned WIDTH = 136,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pkt_replay_gen.sv
// Packet/config replay source: plays frames preloaded into a local flit RAM onto
// the pktin_* interface of a parser block, with per-frame ready sampling,
// inter-frame gap, frame/flit counters and runaway-frame termination.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_wr_i/mem_addr_i/mem_wdata_i   RAM load port, entry = {last, vld, flit}
//   start_i/start_addr_i/num_frames_i/gap_i   run control (start honoured in IDLE)
//   abort_i                       stop at the next frame boundary
//   busy_o, done_o, err_o         status (done 1-cycle pulse, err sticky)
//   frames_sent_o, flits_sent_o   run counters, held after the run
//   pktout_*                      parser bus output; pktout_ready sampled per frame
module pkt_replay_gen
    import pkt_bus_pkg::*;
#(
    parameter  int unsigned DATA_W    = 128,
    parameter  int unsigned MEM_DEPTH = 256,
    parameter  int unsigned MAX_FLITS = 64,
    localparam int unsigned FLIT_W    = DATA_W + 6,
    localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wr_i,
    input  logic [AW-1:0]     mem_addr_i,
    input  logic [FLIT_W+1:0] mem_wdata_i,
    input  logic              start_i,
    input  logic [AW-1:0]     start_addr_i,
    input  logic [15:0]       num_frames_i,
    input  logic [7:0]        gap_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       frames_sent_o,
    output logic [31:0]       flits_sent_o,
    output logic              pktout_data_wr,
    output logic [FLIT_W-1:0] pktout_data,
    output logic              pktout_data_valid,
    output logic              pktout_data_valid_wr,
    input  logic              pktout_ready
);

    localparam int unsigned FCW = $clog2(MAX_FLITS + 1);

    state_t            state, state_nx;
    logic [AW-1:0]     rd_ptr;
    logic [15:0]       num_q;
    logic [7:0]        gap_q;
    logic [7:0]        gap_cnt;
    logic              abort_pend;
    logic [FCW-1:0]    frame_flits;
    logic              rd_en;
    logic [FLIT_W+1:0] rd_data;
    logic              entry_last;
    logic              entry_vld;
    logic              runaway;
    logic              frame_end;

    pkt_flit_ram #(
        .WIDTH (FLIT_W + 2),
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (mem_wr_i),
        .wr_addr (mem_addr_i),
        .wr_data (mem_wdata_i),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // In SEND, rd_data always holds the entry read in the previous cycle; the
    // next read is issued only when that entry does not end the frame, so the
    // pointer never runs past a frame's last entry.
    assign entry_last = rd_data[FLIT_W + ENTRY_LAST_OFS];
    assign entry_vld  = rd_data[FLIT_W + ENTRY_VLD_OFS];
    assign runaway    = (frame_flits == FCW'(MAX_FLITS - 1)) && !entry_last;
    assign frame_end  = (state == ST_SEND) && (entry_last || runaway);
    assign busy_o     = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nx = (num_frames_i == 16'd0) ? ST_DONE : ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (abort_pend) begin
                    state_nx = ST_DONE;
                end else if (pktout_ready) begin
                    rd_en    = 1'b1;
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (frame_end) begin
                    if (frames_sent_o + 16'd1 == num_q) begin
                        state_nx = ST_DONE;
                    end else if (gap_q != 8'd0) begin
                        state_nx = ST_GAP;
                    end else begin
                        state_nx = ST_WAIT_RDY;
                    end
                end else begin
                    rd_en = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort_pend) begin
                    state_nx = ST_DONE;
                end else if (gap_cnt == 8'd1) begin
                    state_nx = ST_WAIT_RDY;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            rd_ptr               <= '0;
            num_q                <= '0;
            gap_q                <= '0;
            gap_cnt              <= '0;
            abort_pend           <= 1'b0;
            frame_flits          <= '0;
            done_o               <= 1'b0;
            err_o                <= 1'b0;
            frames_sent_o        <= '0;
            flits_sent_o         <= '0;
            pktout_data_wr       <= 1'b0;
            pktout_data          <= '0;
            pktout_data_valid    <= 1'b0;
            pktout_data_valid_wr <= 1'b0;
        end else begin
            state                <= state_nx;
            done_o               <= (state == ST_DONE);
            pktout_data_wr       <= 1'b0;
            pktout_data_valid    <= 1'b0;
            pktout_data_valid_wr <= 1'b0;

            if (state == ST_IDLE && start_i) begin
                rd_ptr        <= start_addr_i;
                num_q         <= num_frames_i;
                gap_q         <= gap_i;
                frames_sent_o <= '0;
                flits_sent_o  <= '0;
                err_o         <= 1'b0;
                abort_pend    <= 1'b0;
                frame_flits   <= '0;
            end else if (state == ST_DONE) begin
                abort_pend <= 1'b0;
            end else if (state != ST_IDLE && abort_i) begin
                abort_pend <= 1'b1;
            end

            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            if (state == ST_SEND) begin
                pktout_data_wr <= 1'b1;
                pktout_data    <= rd_data[FLIT_W-1:0];
                flits_sent_o   <= flits_sent_o + 32'd1;
                if (frame_end) begin
                    pktout_data_valid_wr <= 1'b1;
                    pktout_data_valid    <= entry_last & entry_vld;
                    frames_sent_o        <= frames_sent_o + 16'd1;
                    frame_flits          <= '0;
                    gap_cnt              <= gap_q;
                    if (runaway) begin
                        err_o <= 1'b1;
                    end
                end else begin
                    frame_flits <= frame_flits + FCW'(1);
                end
            end

            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

endmodule
